sp_ram_ctrl: RTL and testbench
==============================

Name: sp_ram_ctrl

Overview:
Request-side controller that sits directly upstream of the 1024x8 synchronous single-port RAM and owns its pins (addr, bidirectional data, cs, rd, wr). It accepts read/write commands on a valid/ready interface and buffers them in a small command FIFO. It sequences each command onto the RAM bus and returns read data as a one-cycle response pulse. It never asserts rd and wr together and drives the shared data bus only during write cycles.

Parameters:
AW, 10, RAM address width
DW, 8, RAM data width
FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  command present
req_ready  output  1  command FIFO can accept; = !fifo_full
req_we  input  1  1 = write, 0 = read
req_addr  input  AW  command address
req_wdata  input  DW  write data; ignored for reads
rsp_valid  output  1  one-cycle pulse, read data valid; no backpressure
rsp_rdata  output  DW  read data; held until next rsp_valid
busy  output  1  FIFO non-empty or state != IDLE
ram_cs  output  1  RAM chip select
ram_rd  output  1  RAM read enable
ram_wr  output  1  RAM write enable
ram_addr  output  AW  RAM address
ram_data  inout  DW  RAM data bus; driven with ram_wdata register iff ram_cs && ram_wr, else high-Z

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, FIFO empty, ram_cs/ram_rd/ram_wr = 0, ram_addr = 0, internal write-data register = 0, ram_data high-Z, rsp_valid = 0, rsp_rdata = 0. req_ready is 1 in the cycle after the reset edge.
- Push: the FIFO pushes on req_valid && req_ready. No push can occur when the FIFO is full.
- Pop: the FIFO pops at the edge ending IDLE, WRITE or RD_DATA if non-empty; the popped entry selects the next state. A push and pop in the same cycle are legal; the count is unchanged.
- Pin outputs are registered and decode the current state:
  - IDLE: cs=0, rd=0, wr=0.
  - WRITE: cs=1, wr=1, rd=0, addr/data from the entry. The RAM stores at the edge ending WRITE.
  - RD_ADDR: cs=1, rd=1, wr=0. The RAM loads its output register at the edge ending this state.
  - RD_DATA: cs=1, rd=1, addr held. The RAM drives ram_data; the controller captures it into rsp_rdata at the edge ending RD_DATA, and rsp_valid=1 in the next cycle.
- Transitions:
  - IDLE -> WRITE/RD_ADDR on pop; stay IDLE if the FIFO is empty.
  - WRITE -> WRITE/RD_ADDR on pop; IDLE if the FIFO is empty.
  - RD_ADDR -> RD_DATA unconditionally.
  - RD_DATA -> WRITE/RD_ADDR on pop; IDLE if the FIFO is empty (see optional feature).
- Latency from the accepting edge E0 with IDLE and empty FIFO:
  - Write: pop at E1, RAM writes at E2.
  - Read: RD_ADDR E1-E2, RD_DATA E2-E3, rsp_valid high during E3-E4.
- Throughput: back-to-back writes run at 1 per cycle; reads run at 1 per 2 cycles.
- Ordering: commands complete strictly in FIFO order. A read after a write to the same address returns the new data.
- Invariants: ram_rd && ram_wr is never 1. ram_data is never driven while ram_rd = 1.
- Reset mid-operation: an operation whose pins were asserted in the cycle ending at the reset edge completes at the RAM (the write lands). After the reset edge, pins deassert, the FIFO is flushed, and a pending read produces no rsp_valid.
- Wrap-around: FIFO pointers are log2(FIFO_DEPTH) bits plus a wrap bit. Full = pointers equal with wrap bits differing.

Optional Feature:
SP_RAM_TURNAROUND_EN:
- Defined: a TURN state (cs=rd=wr=0, data high-Z, one cycle) is inserted whenever RD_DATA is followed by WRITE. The WRITE entry is popped at the edge ending RD_DATA and held; TURN -> WRITE.
- Undefined: RD_DATA -> WRITE is direct, with no idle cycle.
- Read->read and write->any sequences are unaffected in both cases.

Test Plan:
- Reset, then write 0x3FF<-0xA5 -> ram_wr pulses 1 cycle with ram_addr=0x3FF, ram_data=0xA5; RAM mem[0x3FF]=0xA5 at E2; busy drops the cycle after.
- Read 0x3FF after that write -> rsp_valid is a single pulse 3 cycles after the accept edge, rsp_rdata=0xA5; ram_data is undriven by the controller throughout.
- Push 5 writes back-to-back with FIFO_DEPTH=4 while the controller is held busy by a leading read -> req_ready deasserts when full; all 5 land in order at addrs 0..4 with data 0x10..0x14.
- Interleave R(0),W(1,0x55),R(1) -> rsp data mem[0] then 0x55. With SP_RAM_TURNAROUND_EN, exactly one cs=0 cycle sits between RD_DATA and WRITE; without it, none.
- Assert rst during RD_DATA of a read to 0x002 -> no rsp_valid; pins 0 and busy=0 after the reset edge; the next read returns correct data.
- Random 2000-command stream against a reference memory model -> all rsp_rdata match; the rd&&wr and drive-while-rd assertions never fire.

Source files
------------

// File: rtl/sp_ram_ctrl.sv
// Command-FIFO controller driving a synchronous single-port RAM.
// Define SP_RAM_TURNAROUND_EN to insert an idle cycle between RD_DATA and WRITE.
module sp_ram_ctrl #(
  parameter int AW         = 10,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          busy,
  output logic          ram_cs,
  output logic          ram_rd,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  inout  wire  [DW-1:0] ram_data
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_ADDR,
    S_RD_DATA
`ifdef SP_RAM_TURNAROUND_EN
    , S_TURN
`endif
  } state_t;

  cmd_t            fifo_q [FIFO_DEPTH];
  logic [PW:0]     wptr_q, wptr_d;
  logic [PW:0]     rptr_q, rptr_d;
  logic            empty, full, push, pop;
  cmd_t            head;

  state_t          state_q, state_d;
  logic            cs_q, cs_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PW] != rptr_q[PW]) &&
                 (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign push  = req_valid && !full;
  assign head  = fifo_q[rptr_q[PW-1:0]];

  assign wptr_d = wptr_q + (PW+1)'(push);
  assign rptr_d = rptr_q + (PW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q[PW-1:0]] <= '{req_we, req_addr, req_wdata};
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_RD_ADDR: state_d = S_RD_DATA;
`ifdef SP_RAM_TURNAROUND_EN
      S_TURN:    state_d = S_WRITE;
`endif
      default: begin
        // IDLE, WRITE and RD_DATA all dispatch the next queued command
        if (!empty) begin
          pop    = 1'b1;
          addr_d = head.addr;
          if (head.we) begin
            wdata_d = head.wdata;
            state_d = S_WRITE;
`ifdef SP_RAM_TURNAROUND_EN
            if (state_q == S_RD_DATA) state_d = S_TURN;
`endif
          end else begin
            state_d = S_RD_ADDR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    cs_d = (state_d == S_WRITE) || (state_d == S_RD_ADDR) ||
           (state_d == S_RD_DATA);
    rd_d = (state_d == S_RD_ADDR) || (state_d == S_RD_DATA);
    wr_d = (state_d == S_WRITE);
    rsp_valid_d = (state_q == S_RD_DATA);
    rsp_rdata_d = (state_q == S_RD_DATA) ? ram_data : rsp_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cs_q        <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cs_q        <= cs_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = !full;
  assign busy      = !empty || (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ram_cs    = cs_q;
  assign ram_rd    = rd_q;
  assign ram_wr    = wr_q;
  assign ram_addr  = addr_q;
  assign ram_data  = (cs_q && wr_q) ? wdata_q : 'z;

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Scoreboard bench for sp_ram_ctrl with a behavioural 1024x8 RAM.
// Honours SP_RAM_TURNAROUND_EN for the RD_DATA->WRITE gap check.
module tb_sp_ram_ctrl;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, busy;
  logic [DW-1:0] rsp_rdata;
  logic          ram_cs, ram_rd, ram_wr;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;

  sp_ram_ctrl #(.AW(AW), .DW(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .ram_cs(ram_cs), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_addr(ram_addr), .ram_data(ram_data)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM
  logic [DW-1:0] ram_mem [1024];
  logic [DW-1:0] ram_q = '0;
  assign ram_data = (ram_cs && ram_rd && !ram_wr) ? ram_q : 'z;
  always @(posedge clk) begin
    if (ram_cs && ram_wr) ram_mem[ram_addr] = ram_data;
    if (ram_cs && ram_rd) ram_q <= ram_mem[ram_addr];
  end

  // Reference model: memory contents in command order
  logic [DW-1:0] refmem [1024];
  logic [DW-1:0] exp_q [$];
  logic [2:0]    trace [$];
  logic          trace_en = 1'b0;
  logic          saw_stall = 1'b0;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected read data whenever the DUT responds
  always @(negedge clk) begin
    if (trace_en) trace.push_back({ram_cs, ram_rd, ram_wr});
    if (!rst) begin
      chk("rd_wr_exclusive", {31'b0, ram_rd && ram_wr}, 0);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rdata %0h expected no rsp",
                   rsp_rdata);
        end else begin
          chk("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, exp_q.pop_front()});
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 100) begin
      saw_stall = 1'b1;
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", {31'b0, req_ready}, 1);
      req_valid = 1'b0;
      return;
    end
    if (we) refmem[a] = d;
    else exp_q.push_back(refmem[a]);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", {31'b0, busy}, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int gap, k, j;
    logic [AW-1:0] a;
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = '0;
      refmem[i]  = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", {31'b0, req_ready}, 1);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_pins", {29'b0, ram_cs, ram_rd, ram_wr}, 0);
    chk("rst_addr", {22'b0, ram_addr}, 0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_rsp_rdata", {24'b0, rsp_rdata}, 0);

    // Single write to the top address
    send(1'b1, 10'h3FF, 8'hA5);
    chk("w_e0_wr", {31'b0, ram_wr}, 0);
    chk("w_e0_busy", {31'b0, busy}, 1);
    @(negedge clk);
    chk("w_e1_pins", {29'b0, ram_cs, ram_rd, ram_wr}, 3'b101);
    chk("w_e1_addr", {22'b0, ram_addr}, 32'h3FF);
    chk("w_e1_data", {24'b0, ram_data}, 32'hA5);
    @(negedge clk);
    chk("w_e2_wr", {31'b0, ram_wr}, 0);
    chk("w_e2_mem", {24'b0, ram_mem[10'h3FF]}, 32'hA5);
    chk("w_e2_busy", {31'b0, busy}, 0);

    // Read it back and check response timing
    send(1'b0, 10'h3FF, 8'h00);
    @(negedge clk);
    chk("r_e1_pins", {29'b0, ram_cs, ram_rd, ram_wr}, 3'b110);
    @(negedge clk);
    chk("r_e2_pins", {29'b0, ram_cs, ram_rd, ram_wr}, 3'b110);
    chk("r_e2_rsp_valid", {31'b0, rsp_valid}, 0);
    @(negedge clk);
    chk("r_e3_rsp_valid", {31'b0, rsp_valid}, 1);
    chk("r_e3_rsp_rdata", {24'b0, rsp_rdata}, 32'hA5);
    @(negedge clk);
    chk("r_e4_rsp_valid", {31'b0, rsp_valid}, 0);
    wait_idle();

    // Leading reads hold the controller so the writes fill the FIFO
    saw_stall = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, AW'(10'h200 + i), 8'h00);
    for (int i = 0; i < 5; i++) send(1'b1, AW'(i), DW'(8'h10 + i));
    chk("fifo_full_stall", {31'b0, saw_stall}, 1);
    wait_idle();
    for (int i = 0; i < 5; i++)
      chk("burst_mem", {24'b0, ram_mem[i]}, 32'h10 + i);

    // Read/write/read interleave and the read-to-write gap
    trace.delete();
    trace_en = 1'b1;
    send(1'b0, 10'd0, 8'h00);
    send(1'b1, 10'd1, 8'h55);
    send(1'b0, 10'd1, 8'h00);
    wait_idle();
    trace_en = 1'b0;
    k = -1;
    for (int i = 0; i < trace.size(); i++)
      if (k < 0 && trace[i][0]) k = i;
    j = -1;
    for (int i = 0; i < trace.size(); i++)
      if (i < k && trace[i][1]) j = i;
    gap = -1;
    if (k >= 0 && j >= 0) begin
      gap = 0;
      for (int i = j + 1; i < k; i++) if (!trace[i][2]) gap++;
    end
`ifdef SP_RAM_TURNAROUND_EN
    chk("turn_gap", gap, 1);
`else
    chk("turn_gap", gap, 0);
`endif

    // Reset while a read sits in RD_DATA
    send(1'b0, 10'd2, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_rd", {31'b0, ram_rd}, 1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_pins", {29'b0, ram_cs, ram_rd, ram_wr}, 0);
    chk("rst_mid_busy", {31'b0, busy}, 0);
    chk("rst_mid_rsp", {31'b0, rsp_valid}, 0);
    chk("rst_mid_ready", {31'b0, req_ready}, 1);
    @(negedge clk);
    chk("rst_mid_rsp2", {31'b0, rsp_valid}, 0);
    send(1'b0, 10'd2, 8'h00);
    wait_idle();

    // Random command stream
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) a = AW'($urandom_range(0, 1023));
      else a = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      send(1'($urandom_range(0, 1)), a, DW'($urandom));
    end
    wait_idle();
    repeat (4) @(negedge clk);
    chk("pending_rsp", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
